pbm_rd_arbiter: RTL
===================

// Module: pbm_rd_arbiter
// PURPOSE
// - Packet-granular read arbiter for the single PBM read port, shared by tx_stack (req 0) and dma_master_engine (req 1).
// - Replaces the combinational busy-based mux ahead of pbm_controller in dma_subsystem.
// - Grant is held for a whole packet until the owner releases it. Non-owners see a forced-empty PBM.
// - TX-priority or round-robin policy, with a starvation guard and an idle-owner timeout.
// PARAMETERS
// - STARVE_LIMIT  default 4    consecutive TX grants allowed while DMA waits (TX-priority mode)
// - IDLE_TIMEOUT  default 1024 cycles a granted owner may sit without ren before forced release
// - CNT_W         default 16   width of statistics counters
// PORTS
// - clk               in   1      clock
// - rst_n             in   1      asynchronous, active-low reset
// - i_cfg_rr          in   1      0 = TX fixed priority, 1 = round robin; sampled only in ARB
// - i_tx_req          in   1      TX wants a packet; level, held until granted
// - i_tx_ren          in   1      TX read strobe
// - i_tx_release      in   1      TX done with packet; 1-cycle pulse
// - o_tx_gnt          out  1      TX owns the read port
// - i_dma_req         in   1      DMA wants a packet
// - i_dma_ren         in   1      DMA read strobe
// - i_dma_release     in   1      DMA done with packet
// - o_dma_gnt         out  1      DMA owns the read port
// - i_pbm_empty       in   1      PBM empty flag
// - o_pbm_ren         out  1      arbitrated read enable to PBM
// - o_tx_empty        out  1      empty seen by TX
// - o_dma_empty       out  1      empty seen by DMA
// - o_timeout         out  1      1-cycle pulse on forced release
// - o_err_ren         out  1      1-cycle pulse when a non-owner asserts ren
// - o_tx_gnt_cnt      out  CNT_W  number of TX grants
// - o_dma_gnt_cnt     out  CNT_W  number of DMA grants
// BEHAVIOUR
// - Reset values: all outputs 0, except o_tx_empty = o_dma_empty = 1. FSM in ARB. Counters 0. RR pointer = TX.
// - FSM states: ARB -> GNT_TX | GNT_DMA -> TURN -> ARB.
//   - ARB: at the edge where any req = 1, latch the winner. Its gnt goes high the next cycle, so latency req -> gnt = 1 cycle.
//   - GNT_x -> TURN: on i_x_release, or on timeout.
//   - TURN: exactly 1 cycle, both gnt = 0. Then -> ARB.
// - Selection, TX-priority mode (i_cfg_rr = 0):
//   - TX wins over DMA.
//   - starve_cnt increments on each TX grant while i_dma_req = 1.
//   - When starve_cnt == STARVE_LIMIT, DMA wins the next ARB even if TX also requests.
//   - starve_cnt clears on any DMA grant, or when i_dma_req = 0 in ARB.
// - Selection, RR mode (i_cfg_rr = 1):
//   - On simultaneous requests, the requester not granted last wins.
//   - The pointer updates on every grant.
// - Datapath (combinational):
//   - o_pbm_ren = (gnt_tx & i_tx_ren | gnt_dma & i_dma_ren) & ~i_pbm_empty.
//   - o_x_empty = i_pbm_empty | ~o_x_gnt.
// - Release and ren in the same cycle: the ren is still forwarded, and the grant drops the next cycle.
// - Non-owner ren (including in ARB/TURN): never forwarded to PBM; o_err_ren pulses.
// - Timeout:
//   - idle_cnt resets to 0 on grant and on every owner ren; it increments otherwise while in GNT_x.
//   - When idle_cnt reaches IDLE_TIMEOUT - 1, force release (-> TURN) and pulse o_timeout.
// - A requester that drops req before being granted is simply not selected; no error is flagged.
// - Release pulse while not owner: ignored.
// - Async reset mid-packet: grant drops immediately; the PBM pointers are the owner's problem.
// CONFIGURATION
// - PBM_ARB_STATS_EN defined:
//   - o_tx_gnt_cnt / o_dma_gnt_cnt increment by 1 at each grant (ARB -> GNT_x).
//   - They saturate at all-ones (no wrap).
// - PBM_ARB_STATS_EN undefined: both counters are tied to 0 and no counter flops are built.
// TESTING
// - Reset: rst_n = 0 mid-GNT_TX -> o_tx_gnt = 0 and o_pbm_ren = 0 with no clock edge; FSM in ARB after release.
// - Simultaneous requests, i_cfg_rr = 0:
//   - i_tx_req = i_dma_req = 1 -> o_tx_gnt = 1 one cycle later.
//   - TX reads 3 words then releases -> 1 TURN cycle -> TX granted again.
// - Starvation, STARVE_LIMIT = 4: TX and DMA request continuously -> grant order TX, TX, TX, TX, DMA, TX, ...
// - RR mode: both request continuously for 4 packets -> grant order alternates TX, DMA, TX, DMA.
// - Gating:
//   - DMA granted, i_tx_ren = 1 -> o_pbm_ren = 0, o_err_ren = 1, o_tx_empty = 1.
//   - i_pbm_empty = 1 with i_dma_ren = 1 -> o_pbm_ren = 0.
// - Timeout, IDLE_TIMEOUT = 8: DMA granted, no ren for 8 cycles -> o_timeout pulse; grant moves to pending TX after TURN.
// - Stats: with PBM_ARB_STATS_EN, 5 TX + 3 DMA packets -> counters read 5 and 3; without the macro both read 0.

Source files
------------

// File: rtl/pbm_rd_arbiter.sv
// pbm_rd_arbiter: packet-granular arbiter for the single PBM read port.
// Requester 0 is tx_stack, requester 1 is dma_master_engine. A grant is held
// for a whole packet until the owner releases it (or goes idle too long).
// Non-owners see a forced-empty PBM and their read strobes are dropped.
// Optional feature macro: PBM_ARB_STATS_EN builds saturating grant counters;
// without it both counter outputs are tied to zero.
module pbm_rd_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int IDLE_TIMEOUT = 1024,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_cfg_rr,
   input  logic             i_tx_req,
   input  logic             i_tx_ren,
   input  logic             i_tx_release,
   output logic             o_tx_gnt,
   input  logic             i_dma_req,
   input  logic             i_dma_ren,
   input  logic             i_dma_release,
   output logic             o_dma_gnt,
   input  logic             i_pbm_empty,
   output logic             o_pbm_ren,
   output logic             o_tx_empty,
   output logic             o_dma_empty,
   output logic             o_timeout,
   output logic             o_err_ren,
   output logic [CNT_W-1:0] o_tx_gnt_cnt,
   output logic [CNT_W-1:0] o_dma_gnt_cnt
);

   localparam int IDLE_W   = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [IDLE_W-1:0]   IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_ARB     = 2'd0,
      ST_GNT_TX  = 2'd1,
      ST_GNT_DMA = 2'd2,
      ST_TURN    = 2'd3
   } state_t;

   state_t              state_q,      state_d;
   logic [IDLE_W-1:0]   idle_cnt_q,   idle_cnt_d;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   // 0: TX wins the next simultaneous round-robin request, 1: DMA wins
   logic                rr_ptr_q,     rr_ptr_d;
   logic                dma_wins_s;
   logic                own_ren_s;
   logic                own_rel_s;
   logic                timeout_s;
   logic                gnt_tx_s;
   logic                gnt_dma_s;

   assign gnt_tx_s  = (state_q == ST_GNT_TX);
   assign gnt_dma_s = (state_q == ST_GNT_DMA);

   // State register and arbitration bookkeeping; reset drops any grant at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ARB;
         idle_cnt_q   <= '0;
         starve_cnt_q <= '0;
         rr_ptr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         idle_cnt_q   <= idle_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   // Owner's own strobes, selected by which grant is active
   always_comb begin
      own_ren_s = 1'b0;
      own_rel_s = 1'b0;
      case (state_q)
         ST_GNT_TX: begin
            own_ren_s = i_tx_ren;
            own_rel_s = i_tx_release;
         end
         ST_GNT_DMA: begin
            own_ren_s = i_dma_ren;
            own_rel_s = i_dma_release;
         end
         default: begin
            own_ren_s = 1'b0;
            own_rel_s = 1'b0;
         end
      endcase
   end

   // Next-state: winner selection in ARB, release/idle timeout in GNT, one-cycle TURN
   always_comb begin
      state_d      = state_q;
      idle_cnt_d   = idle_cnt_q;
      starve_cnt_d = starve_cnt_q;
      rr_ptr_d     = rr_ptr_q;
      dma_wins_s   = 1'b0;
      timeout_s    = 1'b0;
      case (state_q)
         ST_ARB: begin
            idle_cnt_d = '0;
            if (i_cfg_rr) begin
               dma_wins_s = i_dma_req & (~i_tx_req | rr_ptr_q);
            end else begin
               dma_wins_s = i_dma_req & (~i_tx_req | (starve_cnt_q >= STARVE_MAX));
            end
            if (!(i_tx_req | i_dma_req)) begin
               // nobody waiting, so DMA is not being starved
               starve_cnt_d = '0;
            end else if (dma_wins_s) begin
               state_d      = ST_GNT_DMA;
               rr_ptr_d     = 1'b0;
               starve_cnt_d = '0;
            end else begin
               state_d  = ST_GNT_TX;
               rr_ptr_d = 1'b1;
               if (!i_dma_req) begin
                  starve_cnt_d = '0;
               end else if (starve_cnt_q >= STARVE_MAX) begin
                  starve_cnt_d = starve_cnt_q;
               end else begin
                  starve_cnt_d = starve_cnt_q + STARVE_W'(1);
               end
            end
         end
         ST_GNT_TX, ST_GNT_DMA: begin
            if (own_rel_s) begin
               state_d    = ST_TURN;
               idle_cnt_d = '0;
            end else if (own_ren_s) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_LAST) begin
               // owner went quiet for the whole window: take the port back
               state_d    = ST_TURN;
               idle_cnt_d = '0;
               timeout_s  = 1'b1;
            end else begin
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
         end
         ST_TURN: begin
            state_d    = ST_ARB;
            idle_cnt_d = '0;
         end
         default: begin
            state_d    = ST_ARB;
            idle_cnt_d = '0;
         end
      endcase
   end

   assign o_tx_gnt    = gnt_tx_s;
   assign o_dma_gnt   = gnt_dma_s;
   assign o_pbm_ren   = ((gnt_tx_s & i_tx_ren) | (gnt_dma_s & i_dma_ren)) & ~i_pbm_empty;
   assign o_tx_empty  = i_pbm_empty | ~gnt_tx_s;
   assign o_dma_empty = i_pbm_empty | ~gnt_dma_s;
   assign o_timeout   = timeout_s;
   assign o_err_ren   = (i_tx_ren & ~gnt_tx_s) | (i_dma_ren & ~gnt_dma_s);

`ifdef PBM_ARB_STATS_EN
   logic [CNT_W-1:0] tx_cnt_q,  tx_cnt_d;
   logic [CNT_W-1:0] dma_cnt_q, dma_cnt_d;
   logic             new_tx_gnt_s;
   logic             new_dma_gnt_s;

   assign new_tx_gnt_s  = (state_q == ST_ARB) && (state_d == ST_GNT_TX);
   assign new_dma_gnt_s = (state_q == ST_ARB) && (state_d == ST_GNT_DMA);

   // Saturating grant counters, bumped on each ARB -> GNT transition
   always_comb begin
      tx_cnt_d  = tx_cnt_q;
      dma_cnt_d = dma_cnt_q;
      if (new_tx_gnt_s && (tx_cnt_q != {CNT_W{1'b1}})) begin
         tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end else begin
         tx_cnt_d = tx_cnt_q;
      end
      if (new_dma_gnt_s && (dma_cnt_q != {CNT_W{1'b1}})) begin
         dma_cnt_d = dma_cnt_q + CNT_W'(1);
      end else begin
         dma_cnt_d = dma_cnt_q;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_cnt_q  <= '0;
         dma_cnt_q <= '0;
      end else begin
         tx_cnt_q  <= tx_cnt_d;
         dma_cnt_q <= dma_cnt_d;
      end
   end

   assign o_tx_gnt_cnt  = tx_cnt_q;
   assign o_dma_gnt_cnt = dma_cnt_q;
`else
   assign o_tx_gnt_cnt  = {CNT_W{1'b0}};
   assign o_dma_gnt_cnt = {CNT_W{1'b0}};
`endif

endmodule
